control_unit: RTL and testbench



---
 rtl/control_unit.sv | 147 ++++++++++++++
 tb/tb_control_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Brief    : RV32I-style main decoder; opcode -> registered control strobes
//            (1-cycle latency). Optional CONTROL_UNIT_ILLEGAL_EN adds illegal_op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       MemToReg,
    output logic [1:0] ALUSrc,
    output logic [2:0] ALUOp,
    output logic [1:0] Jump
`ifdef CONTROL_UNIT_ILLEGAL_EN
    ,
    output logic       illegal_op
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_branch;
    logic       w_mem_to_reg;
    logic [1:0] w_alu_src;
    logic [2:0] w_alu_op;
    logic [1:0] w_jump;
    logic       w_illegal;

    // Unlisted opcodes fall through to the all-zero default so they act as bubbles.
    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 2'b00;
        w_alu_op     = 3'b000;
        w_jump       = 2'b00;
        w_illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b010;
            end
            OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_src    = 2'b01;
            end
            OP_STORE: begin
                w_mem_write = 1'b1;
                w_alu_src   = 2'b01;
            end
            OP_BRANCH: begin
                w_branch = 1'b1;
                w_alu_op = 3'b001;
            end
            OP_IMM: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b01;
                w_alu_op    = 3'b011;
            end
            OP_JAL: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b11;
                w_alu_op    = 3'b101;
                w_jump      = 2'b01;
            end
            OP_JALR: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b11;
                w_alu_op    = 3'b101;
                w_jump      = 2'b10;
            end
            OP_LUI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b01;
                w_alu_op    = 3'b100;
            end
            OP_AUIPC: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b10;
            end
            default: begin
                w_illegal = (opcode != OP_NOP);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            Branch   <= 1'b0;
            MemToReg <= 1'b0;
            ALUSrc   <= 2'b00;
            ALUOp    <= 3'b000;
            Jump     <= 2'b00;
        end else begin
            RegWrite <= w_reg_write;
            MemRead  <= w_mem_read;
            MemWrite <= w_mem_write;
            Branch   <= w_branch;
            MemToReg <= w_mem_to_reg;
            ALUSrc   <= w_alu_src;
            ALUOp    <= w_alu_op;
            Jump     <= w_jump;
        end
    end

`ifdef CONTROL_UNIT_ILLEGAL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= w_illegal;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench for control_unit; expected decode words are
//            queued at drive time and popped one edge later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       RegWrite, MemRead, MemWrite, Branch, MemToReg;
    logic [1:0] ALUSrc;
    logic [2:0] ALUOp;
    logic [1:0] Jump;
`ifdef CONTROL_UNIT_ILLEGAL_EN
    logic       illegal_op;
`endif

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Branch    (Branch),
        .MemToReg  (MemToReg),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .Jump      (Jump)
`ifdef CONTROL_UNIT_ILLEGAL_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {illegal, RegWrite, MemRead, MemWrite, Branch, MemToReg, ALUSrc, ALUOp, Jump}
    function automatic logic [12:0] model(input logic [6:0] op, input logic r);
        logic [11:0] row;
        logic        ill;
        row = 12'b0;
        ill = 1'b0;
        case (op)
            7'b0110011: row = 12'b1_0_0_0_0_00_010_00;
            7'b0000011: row = 12'b1_1_0_0_1_01_000_00;
            7'b0100011: row = 12'b0_0_1_0_0_01_000_00;
            7'b1100011: row = 12'b0_0_0_1_0_00_001_00;
            7'b0010011: row = 12'b1_0_0_0_0_01_011_00;
            7'b1101111: row = 12'b1_0_0_0_0_11_101_01;
            7'b1100111: row = 12'b1_0_0_0_0_11_101_10;
            7'b0110111: row = 12'b1_0_0_0_0_01_100_00;
            7'b0010111: row = 12'b1_0_0_0_0_10_000_00;
            default:    ill = (op != 7'b0000000);
        endcase
`ifndef CONTROL_UNIT_ILLEGAL_EN
        ill = 1'b0;
`endif
        if (r) return 13'b0;
        return {ill, row};
    endfunction

    function automatic logic [12:0] observed();
        logic ill;
`ifdef CONTROL_UNIT_ILLEGAL_EN
        ill = illegal_op;
`else
        ill = 1'b0;
`endif
        return {ill, RegWrite, MemRead, MemWrite, Branch, MemToReg, ALUSrc, ALUOp, Jump};
    endfunction

    // Drive one opcode for one edge, queue its expected decode, sample #1 after the edge.
    task automatic drive(input logic [6:0] op, input logic r);
        opcode = op;
        rst    = r;
        exp_q.push_back(model(op, r));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        logic [12:0] got;
        for (int i = 0; i < 2; i++) begin
            drive(7'b0110011, 1'b1);
            exp = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_hold%0d got=%b exp=%b", i, got, exp);
            end
        end
        drive(7'b0110011, 1'b0);
        exp = exp_q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_sweep();
        logic [6:0]  ops [10];
        logic [12:0] exp;
        logic [12:0] got;
        ops = '{7'b0000000, 7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], 1'b0);
            exp = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sweep op=%b got=%b exp=%b", ops[i], got, exp);
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  ops [4];
        logic [12:0] exp;
        logic [12:0] got;
        ops = '{7'b1111111, 7'b0000000, 7'b0110001, 7'b1111111};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 1'b0);
            exp = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal op=%b got=%b exp=%b", ops[i], got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [6:0]  ops [4];
        logic        rs  [4];
        logic [12:0] exp;
        logic [12:0] got;
        ops = '{7'b0000011, 7'b0100011, 7'b0100011, 7'b0100011};
        rs  = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], rs[i]);
            exp = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_reset step%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  legal [9];
        logic [6:0]  op;
        logic        r;
        logic [12:0] exp;
        logic [12:0] got;
        legal = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 8)];
            else                           op = 7'($urandom_range(0, 127));
            r = ($urandom_range(0, 19) == 0);
            drive(op, r);
            exp = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random op=%b rst=%b got=%b exp=%b", op, r, got, exp);
            end
            checks++;
            if ((MemRead && MemWrite) || (Branch && Jump != 2'b00) ||
                ALUOp[2:1] == 2'b11 || Jump == 2'b11) begin
                errors++;
                $display("FAIL invariant op=%b got=%b required=no_conflict", op, got);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 7'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sweep();
        test_illegal();
        test_reset_mid_sweep();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
